// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock frame, device ACK.
// Optional macro PS2_TX_RETRY_EN: one automatic resend of the latched byte before reporting error.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [63:0] INHIBIT_CYC = 64'(INHIBIT_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
  localparam logic [63:0] TIMEOUT_CYC = 64'(TIMEOUT_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
  localparam logic [63:0] MAX_CYC     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int          CNT_W       = $clog2(MAX_CYC) + 1;

  // The REQ cycle also holds clk low, so INHIBIT runs one cycle short and the
  // total clk-low window is exactly INHIBIT_CYC cycles.
  localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYC - 64'd2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_next;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fall;

  logic [7:0]       byte_q;
  logic             parity_q;
  logic [9:0]       sreg;
  logic             cur_bit;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] inh_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             fail;
`ifdef PS2_TX_RETRY_EN
  logic             retried;
  logic             retry_go;
`endif

  // Both pins idle high, so the synchronisers reset to 1 to avoid a false fall.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fall    = clk_prev & ~clk_sync;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_next = state;
    fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_go   = 1'b0;
`endif
    case (state)
      S_IDLE, S_DONE, S_ERR: state_next = tx_start ? S_INHIBIT : S_IDLE;
      S_INHIBIT:             if (inh_cnt == '0) state_next = S_REQ;
      S_REQ:                 state_next = S_SHIFT;
      S_SHIFT: begin
        if (fall) begin
          if (bit_cnt == 4'd9) state_next = S_ACK;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      S_ACK: begin
        if (fall) begin
          if (data_sync) fail = 1'b1;
          else           state_next = S_WAIT_IDLE;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync && data_sync) state_next = S_DONE;
        else if (tmo_hit)          fail = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (!retried) begin
        retry_go   = 1'b1;
        state_next = S_INHIBIT;
      end else begin
        state_next = S_ERR;
      end
`else
      state_next = S_ERR;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q   <= '0;
      parity_q <= 1'b0;
      sreg     <= '1;
      cur_bit  <= 1'b1;
      bit_cnt  <= '0;
      inh_cnt  <= '0;
      tmo_cnt  <= '0;
`ifdef PS2_TX_RETRY_EN
      retried  <= 1'b0;
`endif
    end else begin
      if (tx_start && !busy) begin
        byte_q   <= tx_data;
        parity_q <= ~^tx_data;
`ifdef PS2_TX_RETRY_EN
        retried  <= 1'b0;
`endif
      end
`ifdef PS2_TX_RETRY_EN
      if (retry_go) retried <= 1'b1;
`endif

      // Entry into INHIBIT covers both a fresh start and a retry.
      if (state_next == S_INHIBIT && state != S_INHIBIT) begin
        inh_cnt <= INH_LOAD;
      end else if (state == S_INHIBIT && inh_cnt != '0) begin
        inh_cnt <= inh_cnt - CNT_W'(1);
      end

      if (state == S_REQ) begin
        sreg    <= {1'b1, parity_q, byte_q};
        cur_bit <= 1'b0;
        bit_cnt <= '0;
        tmo_cnt <= CNT_W'(1);
      end else if (state == S_SHIFT || state == S_ACK || state == S_WAIT_IDLE) begin
        if (fall) begin
          tmo_cnt <= CNT_W'(1);
          if (state == S_SHIFT) begin
            cur_bit <= sreg[0];
            sreg    <= {1'b1, sreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else if (!tmo_hit) begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign busy        = (state == S_INHIBIT) || (state == S_REQ) || (state == S_SHIFT) ||
                       (state == S_ACK) || (state == S_WAIT_IDLE);
  assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2_data_oe = (state == S_REQ) || (state == S_SHIFT && !cur_bit);
  assign done        = (state == S_DONE);
  assign error       = (state == S_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus model plus a PS/2 device BFM clocking at ~12.5 kHz.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int INHIBIT_US  = 100;
  localparam int TIMEOUT_US  = 2000;
  localparam int INHIBIT_CYC = 100;
  localparam int TIMEOUT_CYC = 2000;
  localparam int SYNC_LAT    = 2;   // pin edge to detected fall
  localparam int HALF        = 40;  // device half period in clk cycles
`ifdef PS2_TX_RETRY_EN
  localparam int TRIES = 2;
`else
  localparam int TRIES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       bfm_clk_low = 1'b0;
  logic       bfm_data_low = 1'b0;
  logic       ps2_clk_pin, ps2_data_pin;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, error;

  int vectors = 0;
  int miscompares = 0;

  assign ps2_clk_pin  = ~(ps2_clk_oe | bfm_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | bfm_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_in (ps2_clk_pin),
    .ps2_data_in(ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   done_cnt = 0, err_cnt = 0, req_cnt = 0, overlap_cnt = 0;
  logic clk_oe_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1)  done_cnt <= done_cnt + 1;
    if (error === 1'b1) err_cnt  <= err_cnt + 1;
    if (ps2_clk_oe === 1'b1 && clk_oe_q !== 1'b1) req_cnt <= req_cnt + 1;
    if ((done === 1'b1 && (error === 1'b1 || busy === 1'b1)) || (error === 1'b1 && busy === 1'b1))
      overlap_cnt <= overlap_cnt + 1;
    clk_oe_q <= ps2_clk_oe;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  // Device side: waits for request-to-send, clocks nclk falling edges
  // (11 = full frame incl. ACK clock), samples data on each rising edge.
  task automatic device_frame(input bit ack_low, input int nclk,
                              output logic [9:0] bits, output bit ok, output int fall_cyc);
    int n;
    bits = '0; ok = 1'b0; fall_cyc = 0; n = 0;
    while (!(ps2_clk_pin === 1'b1 && ps2_data_pin === 1'b0) && n < 3000) begin
      n++;
      tick(1);
    end
    if (n < 3000) begin
      ok = 1'b1;
      tick(20);
      for (int k = 0; k < nclk && k < 10; k++) begin
        bfm_clk_low = 1'b1; fall_cyc = cyc; tick(HALF);
        bfm_clk_low = 1'b0; bits[k] = ps2_data_pin; tick(HALF);
      end
      if (nclk > 10) begin
        bfm_data_low = ack_low; tick(20);
        bfm_clk_low = 1'b1; fall_cyc = cyc; tick(HALF);
        bfm_clk_low = 1'b0; tick(20);
        bfm_data_low = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_data = 8'hF4; tx_start = 1'b1;
    tick(2);
    vectors++;
    if ({busy, ps2_clk_oe, ps2_data_oe, done, error} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 00000", {busy, ps2_clk_oe, ps2_data_oe, done, error});
    end
    rst = 1'b0; tx_start = 1'b0;
    tick(3);
    vectors++;
    if ({busy, ps2_clk_oe} !== 2'b00) begin
      miscompares++;
      $display("FAIL start_with_rst_ignored: busy,clk_oe got %b want 00", {busy, ps2_clk_oe});
    end
  endtask

  task automatic wait_done(input string name, input int d0);
    int n = 0;
    while (done !== 1'b1 && n < 500) begin n++; tick(1); end
    vectors++;
    if ({done, busy, error} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s_done: done,busy,error got %b want 100", name, {done, busy, error});
    end
    tick(5);
    vectors++;
    if (done_cnt - d0 !== 1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt - d0);
    end
  endtask

  task automatic test_f4;
    logic [9:0] bits; bit ok; int fc, n, d0; logic first_d, last_d;
    d0 = done_cnt;
    start_tx(8'hF4);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL f4_busy_rise: got %b want 1", busy); end
    n = 0; first_d = ps2_data_oe; last_d = 1'b0;
    while (ps2_clk_oe === 1'b1 && n < 1000) begin last_d = ps2_data_oe; n++; tick(1); end
    vectors++;
    if (n !== INHIBIT_CYC) begin miscompares++; $display("FAIL f4_inhibit_len: got %0d want %0d", n, INHIBIT_CYC); end
    vectors++;
    if ({first_d, last_d, ps2_data_oe} !== 3'b011) begin
      miscompares++;
      $display("FAIL f4_rts_data: first,req,shift got %b want 011", {first_d, last_d, ps2_data_oe});
    end
    device_frame(1'b1, 11, bits, ok, fc);
    vectors++;
    // bits 0,0,1,0,1,1,1,1 then parity 0, stop 1
    if (!ok || bits !== 10'b10_1111_0100) begin
      miscompares++;
      $display("FAIL f4_frame: got %b ok=%0d want 1011110100", bits, ok);
    end
    wait_done("f4", d0);
  endtask

  task automatic test_ff;
    logic [9:0] bits; bit ok; int fc, d0;
    d0 = done_cnt;
    start_tx(8'hFF);
    device_frame(1'b1, 11, bits, ok, fc);
    vectors++;
    if (!ok || bits[7:0] !== 8'hFF) begin miscompares++; $display("FAIL ff_byte: got %h want ff", bits[7:0]); end
    vectors++;
    if (bits[9:8] !== 2'b11) begin miscompares++; $display("FAIL ff_parity_stop: got %b want 11", bits[9:8]); end
    wait_done("ff", d0);
  endtask

  task automatic test_nack;
    logic [9:0] bits; bit ok; int fc, d0, e0, r0;
    d0 = done_cnt; e0 = err_cnt; r0 = req_cnt;
    start_tx(8'hF4);
    for (int t = 0; t < TRIES; t++) begin
      device_frame(1'b0, 11, bits, ok, fc);
      vectors++;
      if (!ok || bits !== 10'b10_1111_0100) begin
        miscompares++;
        $display("FAIL nack_frame%0d: got %b want 1011110100", t, bits);
      end
    end
    tick(10);
    vectors++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      miscompares++;
      $display("FAIL nack_pulses: error %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL nack_release: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
    end
    vectors++;
    if (req_cnt - r0 !== TRIES) begin miscompares++; $display("FAIL nack_frames: got %0d want %0d", req_cnt - r0, TRIES); end
  endtask

  task automatic test_timeout;
    logic [9:0] bits; bit ok; int fc, n, e0;
    e0 = err_cnt;
    start_tx(8'hF4);
    for (int t = 0; t < TRIES; t++) begin
      n = 0;
      while (t > 0 && ps2_clk_oe !== 1'b1 && n < 3000) begin n++; tick(1); end
      device_frame(1'b1, 4, bits, ok, fc);
      vectors++;
      if (!ok || bits[3:0] !== 4'b0100) begin miscompares++; $display("FAIL tmo_bits%0d: got %b want 0100", t, bits[3:0]); end
    end
    n = 0;
    while (error !== 1'b1 && n < 3000) begin n++; tick(1); end
    vectors++;
    if (error !== 1'b1 || cyc - fc !== TIMEOUT_CYC + SYNC_LAT) begin
      miscompares++;
      $display("FAIL tmo_latency: error=%b after %0d cycles want %0d", error, cyc - fc, TIMEOUT_CYC + SYNC_LAT);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL tmo_release: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
    end
    tick(3);
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL tmo_pulses: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits; bit ok; int fc, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    device_frame(1'b1, 5, bits, ok, fc);
    vectors++;
    if (!ok || busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    tick(1);
    vectors++;
    if ({busy, ps2_clk_oe, ps2_data_oe, done, error} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %b want 00000", {busy, ps2_clk_oe, ps2_data_oe, done, error});
    end
    rst = 1'b0;
    tick(TIMEOUT_CYC + 500);
    vectors++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      miscompares++;
      $display("FAIL mid_no_pulse: done %0d error %0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits; bit ok; int fc, d0, r0;
    d0 = done_cnt; r0 = req_cnt;
    start_tx(8'hED);
    tick(10);
    start_tx(8'h00);
    device_frame(1'b1, 11, bits, ok, fc);
    vectors++;
    // 0xED has six ones, so parity is 1
    if (!ok || bits !== 10'b11_1110_1101) begin
      miscompares++;
      $display("FAIL b2b_frame: got %b want 1111101101", bits);
    end
    wait_done("b2b", d0);
    tick(200);
    vectors++;
    if (req_cnt - r0 !== 1) begin miscompares++; $display("FAIL b2b_frames: got %0d want 1", req_cnt - r0); end
    vectors++;
    if (overlap_cnt !== 0) begin miscompares++; $display("FAIL pulse_overlap: got %0d want 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_f4();
    test_ff();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
